// File: rtl/mem_arbiter.sv
// N-port block-request arbiter onto one registered, back-pressurable memory channel.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority (port 0 highest).
module mem_arbiter #(
  parameter int unsigned N_PORTS         = 2,
  parameter int unsigned ADDR_WIDTH      = 26,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned ID_WIDTH       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
  localparam int unsigned CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                           clk,
  input  logic                           rst_aL,
  input  logic [N_PORTS-1:0]             req_valid,
  output logic [N_PORTS-1:0]             req_ready,
  input  logic [N_PORTS-1:0]             req_type,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  req_data,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic                           mem_req_type,
  output logic [ID_WIDTH-1:0]            mem_req_id,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [DATA_WIDTH-1:0]          mem_req_data,
  input  logic                           mem_resp_valid,
  input  logic [ID_WIDTH-1:0]            mem_resp_id,
  input  logic [DATA_WIDTH-1:0]          mem_resp_data,
  output logic [N_PORTS-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           err_bad_resp
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(MAX_OUTSTANDING);

  typedef enum logic {StEmpty, StFull} stage_e;

  stage_e                  state_q, state_d;
  logic                    type_q, type_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [CNT_WIDTH-1:0]    out_cnt_q [N_PORTS];
  logic [CNT_WIDTH-1:0]    out_cnt_d [N_PORTS];
  logic                    err_q, err_d;

  logic [N_PORTS-1:0]      eligible;
  logic [N_PORTS-1:0]      grant;
  logic [N_PORTS-1:0]      resp_hit;
  logic [ID_WIDTH-1:0]     grant_idx;
  logic                    grant_any;
  logic                    load_en;
  logic                    handshake;
  logic                    sel_type;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  // Writes never count against the outstanding-read cap.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      eligible[i] = req_valid[i] & (req_type[i] | (out_cnt_q[i] < CntMax));
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

  // Two passes: indices at/after the pointer first, then the wrapped-around ones.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (!grant_any && eligible[i] && (i >= int'(rr_ptr_q))) begin
        grant_any = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_WIDTH'(i);
      end
    end
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (!grant_any && eligible[i] && (i < int'(rr_ptr_q))) begin
        grant_any = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (handshake) begin
      if (grant_idx == ID_WIDTH'(N_PORTS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (!grant_any && eligible[i]) begin
        grant_any = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_WIDTH'(i);
      end
    end
  end
`endif

  assign load_en   = (state_q == StEmpty) | mem_req_ready;
  // Gated by reset so no requestor sees an acceptance while the block is held in reset.
  assign req_ready = rst_aL ? (grant & {N_PORTS{load_en}}) : '0;
  assign handshake = |req_ready;

  always_comb begin
    sel_type = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      if (grant[i]) begin
        sel_type = req_type[i];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    id_d    = id_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_en) begin
      if (handshake) begin
        state_d = StFull;
        type_d  = sel_type;
        id_d    = grant_idx;
        addr_d  = sel_addr;
        data_d  = sel_type ? sel_data : '0;
      end else begin
        state_d = StEmpty;
      end
    end
  end

  assign mem_req_valid = (state_q == StFull);
  assign mem_req_type  = type_q;
  assign mem_req_id    = id_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = data_q;

  // A response matches only an in-range port with a read in flight; anything else is bad.
  always_comb begin
    resp_hit = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      resp_hit[i] = mem_resp_valid && (mem_resp_id == ID_WIDTH'(i)) && (out_cnt_q[i] != '0);
    end
  end

  assign resp_valid = resp_hit;
  assign resp_data  = mem_resp_data;
  assign err_d      = err_q | (mem_resp_valid & ~(|resp_hit));
  assign err_bad_resp = err_q;

  always_comb begin
    for (int i = 0; i < int'(N_PORTS); i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      if (req_ready[i] && !req_type[i] && !resp_hit[i] && (out_cnt_q[i] != CntMax)) begin
        out_cnt_d[i] = out_cnt_q[i] + 1'b1;
      end else if (resp_hit[i] && !(req_ready[i] && !req_type[i])) begin
        out_cnt_d[i] = out_cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      state_q <= StEmpty;
      type_q  <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(N_PORTS); i++) begin
        out_cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      for (int i = 0; i < int'(N_PORTS); i++) begin
        out_cnt_q[i] <= out_cnt_d[i];
      end
    end
  end

endmodule
